// File: rtl/tdm_demux_pkg.sv
// Shared defaults and state encodings for the 1:8 TDM receive demultiplexer.
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds a trailing even-parity slot).
package tdm_demux_pkg;

  localparam int DEF_N_CH  = 8;
  localparam int DEF_SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: sync clear, load-to-1 (slot 0 already consumed) and increment.
module tdm_slot_counter #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load1,
  input  logic             en,
  output logic [SEL_W-1:0] cnt,
  output logic             last
);

  // Counter register; clear wins over load, load wins over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SEL_W'(1);
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == SEL_W'(N_CH - 1));

endmodule

// File: rtl/tdm_demux_1x8.sv
// 1:8 TDM serial-to-parallel demultiplexer with frame sync detection.
// Optional feature macro: TDM_DEMUX_PARITY_EN (even-parity slot after the data slots).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a valid bit qualified by frame_start
// ST_RECV | collecting data slots 1..N_CH-1 into the shadow register
// ST_PAR  | waiting for the parity slot (parity build only)
module tdm_demux_1x8
  import tdm_demux_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  dout,
  output logic             dout_valid,
  output logic             sync_err,
  output logic             parity_err
);

  state_t          state, state_d;
  logic [N_CH-1:0] shadow;
  logic            last;
  logic            restart;
  logic            store;
  logic            complete;
  logic            par_done;
  logic            sync_d;

  tdm_slot_counter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (store && last),
    .load1 (restart),
    .en    (store && !last),
    .cnt   (sel),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and per-cycle datapath controls; idle cycles (din_valid=0) change nothing.
  always_comb begin
    state_d  = state;
    restart  = 1'b0;
    store    = 1'b0;
    complete = 1'b0;
    par_done = 1'b0;
    sync_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (din_valid && frame_start) begin
          restart = 1'b1;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (din_valid) begin
          if (frame_start) begin
            restart = 1'b1;
            sync_d  = 1'b1;
          end else begin
            store = 1'b1;
            if (last) begin
`ifdef TDM_DEMUX_PARITY_EN
              state_d = ST_PAR;
`else
              complete = 1'b1;
              state_d  = ST_IDLE;
`endif
            end
          end
        end
      end
`ifdef TDM_DEMUX_PARITY_EN
      ST_PAR: begin
        if (din_valid) begin
          if (frame_start) begin
            restart = 1'b1;
            sync_d  = 1'b1;
            state_d = ST_RECV;
          end else begin
            par_done = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow assembly, output word and single-cycle strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      sync_err   <= sync_d;
      if (restart) begin
        shadow <= {{(N_CH-1){1'b0}}, din};
      end else if (store) begin
        shadow[sel] <= din;
      end
      if (complete) begin
        dout       <= {din, shadow[N_CH-2:0]};
        dout_valid <= 1'b1;
      end else if (par_done) begin
        dout       <= shadow;
        dout_valid <= 1'b1;
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Even parity over data plus parity slot, flagged alongside dout_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_done && (^{shadow, din});
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed bench for tdm_demux_1x8; parity test active when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux_1x8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [2:0] sel;
  logic [7:0] dout;
  logic       dout_valid;
  logic       sync_err;
  logic       parity_err;

  int checks = 0;
  int failures = 0;

  tdm_demux_1x8 dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .sel         (sel),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .sync_err    (sync_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] frame;
    logic       gapped;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    din = b;
    frame_start = fs;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    frame_start = 1'b0;
    din = 1'b0;
  endtask

  // Sends a full frame (plus parity slot in the parity build); leaves the bench in
  // the cycle where dout_valid is expected high so the next frame can follow back-to-back.
  task automatic send_frame(input logic [7:0] data, input logic gapped, input logic [7:0] exp_dout,
                            input logic par, input logic exp_perr);
    for (int i = 0; i < 8; i++) begin
      if (gapped && i > 0) begin
        for (int g = 0; g < (i % 5) + 1; g++) begin
          tick();
          check("gap_no_valid", dout_valid, 0);
          check("gap_sel_hold", sel, i);
        end
      end
      check("sel_step", sel, i);
      send_bit(data[i], i == 0);
      if (i < 7) check("no_early_valid", dout_valid, 0);
    end
`ifdef TDM_DEMUX_PARITY_EN
    check("no_valid_before_par", dout_valid, 0);
    check("sel_at_par", sel, 0);
    send_bit(par, 1'b0);
    check("parity_err", parity_err, exp_perr);
`endif
    check("dout_valid", dout_valid, 1);
    check("dout", dout, exp_dout);
    check("sel_wrap", sel, 0);
  endtask

  initial begin
    logic [7:0] w;
    vecs[0] = '{8'hA5, 1'b0, 8'hA5};
    vecs[1] = '{8'h01, 1'b0, 8'h01};
    vecs[2] = '{8'h02, 1'b0, 8'h02};
    vecs[3] = '{8'h04, 1'b0, 8'h04};
    vecs[4] = '{8'h08, 1'b0, 8'h08};
    vecs[5] = '{8'h10, 1'b0, 8'h10};
    vecs[6] = '{8'h20, 1'b0, 8'h20};
    vecs[7] = '{8'h40, 1'b0, 8'h40};
    vecs[8] = '{8'h80, 1'b0, 8'h80};
    vecs[9] = '{8'h3C, 1'b1, 8'h3C};

    // reset values
    tick();
    tick();
    check("rst_sel", sel, 0);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_sync", sync_err, 0);
    check("rst_perr", parity_err, 0);
    rst = 1'b0;
    tick();

    // bit without frame_start in IDLE is ignored silently
    send_bit(1'b1, 1'b0);
    check("idle_ignore_sel", sel, 0);
    check("idle_ignore_sync", sync_err, 0);
    check("idle_ignore_valid", dout_valid, 0);

    // table frames: A5, walking one back-to-back, then gapped 3C
    for (int v = 0; v < 10; v++) begin
      send_frame(vecs[v].frame, vecs[v].gapped, vecs[v].exp_dout, ^vecs[v].frame, 1'b0);
    end
    tick();
    check("valid_one_cycle", dout_valid, 0);
    check("dout_hold", dout, 8'h3C);

    // frame_start again at slot 4, then full frame F0 whose slot0 is the restart bit
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    send_bit(1'b0, 1'b1);
    check("sync_err_pulse", sync_err, 1);
    check("sync_sel_restart", sel, 1);
    check("sync_no_valid", dout_valid, 0);
    check("sync_dout_hold", dout, 8'h3C);
    w = 8'hF0;
    for (int i = 1; i < 8; i++) begin
      send_bit(w[i], 1'b0);
      check("sync_err_once", sync_err, 0);
      if (i < 7) check("sync_partial_hidden", dout_valid, 0);
    end
`ifdef TDM_DEMUX_PARITY_EN
    check("f0_no_valid_before_par", dout_valid, 0);
    send_bit(1'b0, 1'b0);
    check("f0_parity_err", parity_err, 0);
`endif
    check("f0_valid", dout_valid, 1);
    check("f0_dout", dout, 8'hF0);
    tick();
    check("f0_valid_one", dout_valid, 0);

    // reset after slot 5 discards the partial frame
    w = 8'hFF;
    for (int i = 0; i < 6; i++) send_bit(w[i], i == 0);
    check("pre_rst_sel", sel, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_dout", dout, 0);
    check("midrst_sel", sel, 0);
    check("midrst_valid", dout_valid, 0);
    tick();
    check("midrst_valid_after", dout_valid, 0);
    send_frame(8'h81, 1'b0, 8'h81, 1'b0, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
    tick();
    send_frame(8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0);
    tick();
    check("perr_clear", parity_err, 0);
    send_frame(8'hA5, 1'b0, 8'hA5, 1'b1, 1'b1);
    tick();
    check("perr_one_cycle", parity_err, 0);
`else
    check("perr_tied", parity_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
